// File: rtl/xor_share_arbiter.sv
// rtl/xor_share_arbiter.sv - round-robin arbiter sharing one combinational XOR unit between two requesters
module xor_share_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  input  logic          rsp0_ack,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  input  logic          rsp1_ack,
  output logic [DW-1:0] xor_a,
  output logic [DW-1:0] xor_b,
  input  logic [DW-1:0] xor_z,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] op_a, op_b, result;
  logic [DW-1:0] rsp0_q, rsp1_q;
  logic          grant_id, last_grant;
  logic          grant, accept, ack;

  // Round-robin pick: a lone requester wins; on contention, the one not served last
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  // Ready is combinational from IDLE; gated by rst_n so nothing is offered while reset is held
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
    ack        = (state == RESP) && (grant_id ? rsp1_ack : rsp0_ack);
    rsp0_valid = (state == RESP) && !grant_id;
    rsp1_valid = (state == RESP) &&  grant_id;
    rsp0_data  = rsp0_valid ? result : rsp0_q;
    rsp1_data  = rsp1_valid ? result : rsp1_q;
    xor_a      = op_a;
    xor_b      = op_b;
    busy       = (state != IDLE);
  end

  // Next-state logic: one EXEC cycle, RESP holds until the granted requester acks
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: latch operands on accept, capture XOR result, retire into per-requester hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      rsp0_q     <= '0;
      rsp1_q     <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a     <= grant ? req1_a : req0_a;
          op_b     <= grant ? req1_b : req0_b;
          grant_id <= grant;
        end
        EXEC: result <= xor_z;
        RESP: if (ack) begin
          last_grant <= grant_id;
          if (grant_id) rsp1_q <= result;
          else          rsp0_q <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb/tb_xor_share_arbiter.sv - directed self-checking bench for xor_share_arbiter
module tb_xor_share_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, rsp0_ack, rsp1_ack;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [DW-1:0] rsp0_data, rsp1_data, xor_a, xor_b, xor_z;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared XOR unit modelled outside the DUT
  assign xor_z = xor_a ^ xor_b;

  xor_share_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ack(rsp0_ack),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ack(rsp1_ack),
    .xor_a(xor_a), .xor_b(xor_b), .xor_z(xor_z), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ack = 0; rsp1_ack = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 1; rsp0_ack = 0; rsp1_ack = 0;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
    @(negedge clk);
    #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got %b exp 0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready1 got %b exp 0", req1_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 00", {rsp0_valid, rsp1_valid}); end
    n_cmp++; if ({rsp0_data, rsp1_data} !== 16'h0000) begin n_bad++; $display("FAIL reset_rsp_data got %h exp 0000", {rsp0_data, rsp1_data}); end
    n_cmp++; if ({xor_a, xor_b} !== 16'h0000) begin n_bad++; $display("FAIL reset_xor_ops got %h exp 0000", {xor_a, xor_b}); end
    do_reset();
  endtask

  task automatic test_basic();
    req0_a = 8'hF0; req0_b = 8'h0F; req0_valid = 1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready0 got %b exp 1", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready1 got %b exp 0", req1_ready); end
    tick();
    req0_valid = 0;
    n_cmp++; if (rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL basic_exec_valid got %b exp 0", rsp0_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_exec_busy got %b exp 1", busy); end
    n_cmp++; if ({xor_a, xor_b} !== 16'hF00F) begin n_bad++; $display("FAIL basic_xor_ops got %h exp f00f", {xor_a, xor_b}); end
    tick();
    n_cmp++; if (rsp0_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rsp_valid got %b exp 1", rsp0_valid); end
    n_cmp++; if (rsp0_data !== 8'hFF) begin n_bad++; $display("FAIL basic_rsp_data got %h exp ff", rsp0_data); end
    rsp0_ack = 1;
    tick();
    rsp0_ack = 0;
    n_cmp++; if ({rsp0_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_after_ack got %b exp 00", {rsp0_valid, busy}); end
    n_cmp++; if (rsp0_data !== 8'hFF) begin n_bad++; $display("FAIL basic_data_hold got %h exp ff", rsp0_data); end
  endtask

  task automatic test_round_robin();
    logic          g;
    logic [DW-1:0] exp_d;
    do_reset();
    req0_a = 8'hAA; req0_b = 8'h55; req1_a = 8'h3C; req1_b = 8'h3C;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      exp_d = g ? 8'h00 : 8'hFF;
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== {g, ~g}) begin n_bad++; $display("FAIL rr_ready op%0d got %b exp %b", i, {req1_ready, req0_ready}, {g, ~g}); end
      tick();
      tick();
      n_cmp++; if ({rsp1_valid, rsp0_valid} !== {g, ~g}) begin n_bad++; $display("FAIL rr_rsp_valid op%0d got %b exp %b", i, {rsp1_valid, rsp0_valid}, {g, ~g}); end
      n_cmp++; if ((g ? rsp1_data : rsp0_data) !== exp_d) begin n_bad++; $display("FAIL rr_rsp_data op%0d got %h exp %h", i, (g ? rsp1_data : rsp0_data), exp_d); end
      if (g) rsp1_ack = 1; else rsp0_ack = 1;
      tick();
      rsp0_ack = 0; rsp1_ack = 0;
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    n_cmp++; if (rsp0_data !== 8'hFF) begin n_bad++; $display("FAIL rr_rsp0_hold got %h exp ff", rsp0_data); end
    n_cmp++; if (rsp1_data !== 8'h00) begin n_bad++; $display("FAIL rr_rsp1_hold got %h exp 00", rsp1_data); end
  endtask

  task automatic test_hold();
    req0_a = 8'h12; req0_b = 8'h34; req0_valid = 1;
    tick();
    tick();
    req1_a = 8'h01; req1_b = 8'h02; req1_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if ({rsp0_valid, rsp0_data} !== {1'b1, 8'h26}) begin n_bad++; $display("FAIL hold_rsp cyc%0d got %b/%h exp 1/26", i, rsp0_valid, rsp0_data); end
      n_cmp++; if ({req0_ready, req1_ready, busy} !== 3'b001) begin n_bad++; $display("FAIL hold_ready_busy cyc%0d got %b exp 001", i, {req0_ready, req1_ready, busy}); end
      tick();
    end
  endtask

  task automatic test_stray_ack();
    req0_valid = 0;
    rsp1_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, 8'h26}) begin n_bad++; $display("FAIL stray_ack cyc%0d got %b/%h exp 10/26", i, {rsp0_valid, rsp1_valid}, rsp0_data); end
    end
    rsp1_ack = 0; req1_valid = 0;
    rsp0_ack = 1;
    tick();
    rsp0_ack = 0;
    n_cmp++; if ({rsp0_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL stray_final_ack got %b exp 00", {rsp0_valid, busy}); end
  endtask

  task automatic test_reset_mid();
    req0_a = 8'h5A; req0_b = 8'hA5; req0_valid = 1;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_exec_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, rsp0_valid, rsp1_valid, req0_ready} !== 4'b0000) begin n_bad++; $display("FAIL mid_reset_ctrl got %b exp 0000", {busy, rsp0_valid, rsp1_valid, req0_ready}); end
    n_cmp++; if ({xor_a, xor_b, rsp0_data} !== 24'h0) begin n_bad++; $display("FAIL mid_reset_data got %h exp 000000", {xor_a, xor_b, rsp0_data}); end
    req0_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({rsp0_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL mid_no_rsp cyc%0d got %b exp 00", i, {rsp0_valid, busy}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    int            last_acc;
    req0_valid = 1; rsp0_ack = 1;
    last_acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = DW'($urandom); b = DW'($urandom);
      req0_a = a; req0_b = b;
      #1;
      n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready op%0d got %b exp 1", i, req0_ready); end
      if (i > 0) begin
        n_cmp++; if (cyc - last_acc !== 3) begin n_bad++; $display("FAIL b2b_spacing op%0d got %0d exp 3", i, cyc - last_acc); end
      end
      last_acc = cyc;
      tick();
      n_cmp++; if ({xor_a, xor_b} !== {a, b}) begin n_bad++; $display("FAIL b2b_xor_ops op%0d got %h exp %h", i, {xor_a, xor_b}, {a, b}); end
      n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_exec_ready op%0d got %b exp 0", i, req0_ready); end
      tick();
      n_cmp++; if ({rsp0_valid, rsp0_data} !== {1'b1, a ^ b}) begin n_bad++; $display("FAIL b2b_rsp op%0d got %b/%h exp 1/%h", i, rsp0_valid, rsp0_data, a ^ b); end
      tick();
    end
    req0_valid = 0; rsp0_ack = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_stray_ack();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
